// File: rtl/musa_pkg.sv
// Shared encodings for the load/store stage: access sizes and the two-state
// request sequencer.
package musa_pkg;

   typedef logic [1:0] mem_size_t;

   localparam mem_size_t SZ_BYTE = 2'b00;
   localparam mem_size_t SZ_HALF = 2'b01;
   localparam mem_size_t SZ_WORD = 2'b10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables and replicated store data on the way
// out, lane extraction and sign/zero extension on the way back.
module mem_align
   import musa_pkg::*;
(
   input  logic [1:0]  st_lane_i,
   input  mem_size_t   st_size_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   output logic        st_misalign_o,
   input  logic [1:0]  ld_lane_i,
   input  mem_size_t   ld_size_i,
   input  logic        ld_unsigned_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be_o       = 4'b1111;
      st_wdata_o    = st_data_i;
      st_misalign_o = 1'b0;
      case (st_size_i)
         SZ_BYTE: begin
            st_be_o    = 4'b0001 << st_lane_i;
            st_wdata_o = {4{st_data_i[7:0]}};
         end
         SZ_HALF: begin
            st_be_o       = st_lane_i[1] ? 4'b1100 : 4'b0011;
            st_wdata_o    = {2{st_data_i[15:0]}};
            st_misalign_o = st_lane_i[0];
         end
         SZ_WORD: st_misalign_o = (st_lane_i != 2'b00);
         // The unused encoding behaves as a word access.
         default: st_misalign_o = (st_lane_i != 2'b00);
      endcase
   end

   always_comb begin
      ld_byte = ld_rdata_i[7:0];
      case (ld_lane_i)
         2'd0: ld_byte = ld_rdata_i[7:0];
         2'd1: ld_byte = ld_rdata_i[15:8];
         2'd2: ld_byte = ld_rdata_i[23:16];
         2'd3: ld_byte = ld_rdata_i[31:24];
         default: ld_byte = ld_rdata_i[7:0];
      endcase
      ld_half = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
      case (ld_size_i)
         SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'd0, ld_byte}
                                            : {{24{ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data_o = ld_unsigned_i ? {16'd0, ld_half}
                                            : {{16{ld_half[15]}}, ld_half};
         default: ld_data_o = ld_rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Load/store pipeline stage: issues one data-memory request at a time, stalls
// upstream while it is outstanding and registers results toward write-back.
module mem_stage
   import musa_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       store_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [4:0]        rd_in,
   input  logic              reg_write_in,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic [4:0]        wb_rd,
   output logic              wb_reg_write,
   output logic              misalign,
   output logic              bus_error
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [4:0]        rd_q, rd_d;
   mem_size_t         size_q, size_d;
   logic [1:0]        lane_q, lane_d;
   logic              uns_q, uns_d;
   logic              regw_q, regw_d;
   logic              wbv_q, wbv_d;
   logic [31:0]       wbdata_q, wbdata_d;
   logic [4:0]        wbrd_q, wbrd_d;
   logic              wbrw_q, wbrw_d;
   logic              mis_q, mis_d;
   logic              berr_q, berr_d;

   logic [3:0]        st_be;
   logic [31:0]       st_wdata;
   logic              st_misalign;
   logic [31:0]       ld_data;

   mem_align u_align (
      .st_lane_i     (alu_result[1:0]),
      .st_size_i     (mem_size),
      .st_data_i     (store_data),
      .st_be_o       (st_be),
      .st_wdata_o    (st_wdata),
      .st_misalign_o (st_misalign),
      .ld_lane_i     (lane_q),
      .ld_size_i     (size_q),
      .ld_unsigned_i (uns_q),
      .ld_rdata_i    (dmem_rdata),
      .ld_data_o     (ld_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      rd_d     = rd_q;
      size_d   = size_q;
      lane_d   = lane_q;
      uns_d    = uns_q;
      regw_d   = regw_q;
      wbv_d    = 1'b0;
      wbdata_d = wbdata_q;
      wbrd_d   = wbrd_q;
      wbrw_d   = wbrw_q;
      mis_d    = 1'b0;
      berr_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (!mem_read && !mem_write) begin
                  wbv_d    = 1'b1;
                  wbdata_d = alu_result;
                  wbrd_d   = rd_in;
                  wbrw_d   = reg_write_in;
               end else if (st_misalign) begin
                  // Faulting address is reported on wb_data for debug visibility.
                  wbv_d    = 1'b1;
                  mis_d    = 1'b1;
                  wbdata_d = alu_result;
                  wbrd_d   = rd_in;
                  wbrw_d   = 1'b0;
               end else begin
                  state_d = ST_REQ;
                  cnt_d   = '0;
                  addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
                  be_d    = st_be;
                  wdata_d = st_wdata;
                  we_d    = mem_write;
                  rd_d    = rd_in;
                  size_d  = mem_size;
                  lane_d  = alu_result[1:0];
                  uns_d   = mem_unsigned;
                  regw_d  = reg_write_in;
               end
            end
         end
         ST_REQ: begin
            if (dmem_ready) begin
               state_d  = ST_IDLE;
               wbv_d    = 1'b1;
               wbrd_d   = rd_q;
               wbdata_d = we_q ? 32'd0 : ld_data;
               wbrw_d   = we_q ? 1'b0 : regw_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               wbv_d   = 1'b1;
               berr_d  = 1'b1;
               wbrd_d  = rd_q;
               wbrw_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         rd_q     <= '0;
         size_q   <= SZ_BYTE;
         lane_q   <= '0;
         uns_q    <= 1'b0;
         regw_q   <= 1'b0;
         wbv_q    <= 1'b0;
         wbdata_q <= '0;
         wbrd_q   <= '0;
         wbrw_q   <= 1'b0;
         mis_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         size_q   <= size_d;
         lane_q   <= lane_d;
         uns_q    <= uns_d;
         regw_q   <= regw_d;
         wbv_q    <= wbv_d;
         wbdata_q <= wbdata_d;
         wbrd_q   <= wbrd_d;
         wbrw_q   <= wbrw_d;
         mis_q    <= mis_d;
         berr_q   <= berr_d;
      end
   end

   assign stall        = (state_q == ST_REQ);
   assign dmem_req     = (state_q == ST_REQ);
   assign dmem_we      = (state_q == ST_REQ) && we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign wb_valid     = wbv_q;
   assign wb_data      = wbdata_q;
   assign wb_rd        = wbrd_q;
   assign wb_reg_write = wbrw_q;
   assign misalign     = mis_q;
   assign bus_error    = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected write-back records are queued when an
// instruction is driven and popped when wb_valid is observed.
module tb_mem_stage;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [4:0]  rd_in;
   logic        reg_write_in;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        misalign;
   logic        bus_error;

   mem_stage #(.TIMEOUT(16), .ADDR_W(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .alu_result   (alu_result),
      .store_data   (store_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .rd_in        (rd_in),
      .reg_write_in (reg_write_in),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_be      (dmem_be),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .misalign     (misalign),
      .bus_error    (bus_error)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        rw;
      logic        mis;
      logic        berr;
      logic        chk_data;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   stall_cnt;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] r, input logic rw,
                       input logic mis, input logic berr, input logic cd);
      exp_t e;
      e.data = d; e.rd = r; e.rw = rw; e.mis = mis; e.berr = berr; e.chk_data = cd;
      sbq.push_back(e);
   endtask

   task automatic check_retire(input string tag);
      exp_t e;
      chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
      if (wb_valid) begin
         if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sbq.pop_front();
            if (e.chk_data) chk({tag, "_wb_data"}, wb_data, e.data);
            chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
            chk({tag, "_wb_rw"}, {31'd0, wb_reg_write}, {31'd0, e.rw});
            chk({tag, "_misalign"}, {31'd0, misalign}, {31'd0, e.mis});
            chk({tag, "_bus_error"}, {31'd0, bus_error}, {31'd0, e.berr});
         end
      end
      $display("txn %s: wb_valid=%0b data=%08h rd=%0d rw=%0b mis=%0b berr=%0b",
               tag, wb_valid, wb_data, wb_rd, wb_reg_write, misalign, bus_error);
   endtask

   task automatic drive(input logic rd_op, input logic wr_op, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic rw);
      in_valid = 1'b1; mem_read = rd_op; mem_write = wr_op; mem_size = sz;
      mem_unsigned = uns; alu_result = addr; store_data = sdata; rd_in = rd;
      reg_write_in = rw;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // Accept one aligned memory op, answer it after 'waits' empty REQ cycles.
   task automatic mem_op(input string tag, input logic is_load, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int waits, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata);
      drive(is_load, !is_load, sz, uns, addr, sdata, 5'd9, 1'b1);
      step();
      idle_inputs();
      chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, !is_load});
      chk({tag, "_addr"}, dmem_addr, e_addr);
      chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, e_be});
      if (!is_load) chk({tag, "_wdata"}, dmem_wdata, e_wdata);
      stall_cnt = 0;
      for (int i = 0; i <= waits; i++) begin
         if (stall) stall_cnt++;
         if (i == waits) begin
            chk({tag, "_addr_hold"}, dmem_addr, e_addr);
            dmem_ready = 1'b1;
            dmem_rdata = rdata;
         end
         step();
      end
      dmem_ready = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      chk({tag, "_stall_cycles"}, stall_cnt, waits + 1);
      chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
      check_retire(tag);
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      mem_size = 2'b00; mem_unsigned = 1'b0; alu_result = '0; store_data = '0;
      rd_in = '0; reg_write_in = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      reset = 1'b1;
      step();

      // Back-to-back non-memory ops retire one per cycle without stalling.
      drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
      push(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      chk("alu0_stall", {31'd0, stall}, 32'd0);
      check_retire("alu0");
      drive(1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE_0000, 32'h0, 5'd7, 1'b0);
      push(32'hCAFE_0000, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("alu1_stall", {31'd0, stall}, 32'd0);
      check_retire("alu1");
      idle_inputs();
      step();
      chk("alu_pulse_end", {31'd0, wb_valid}, 32'd0);
      chk("alu_hold_data", wb_data, 32'hCAFE_0000);

      push(32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      mem_op("sb", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'hAABB_CCDD, 32'h0, 2,
             32'h0000_0100, 4'b1000, 32'hDDDD_DDDD);
      push(32'hFFFF_8001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      mem_op("lh_s", 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0,
             32'h0000_0200, 4'b1100, 32'h0);
      push(32'h0000_8001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      mem_op("lh_u", 1'b1, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0,
             32'h0000_0200, 4'b1100, 32'h0);
      push(32'hFFFF_FFA6, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      mem_op("lb_s", 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0, 32'h1234_A678, 1,
             32'h0000_0300, 4'b0010, 32'h0);
      push(32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      mem_op("sh", 1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h1111_BEEF, 32'h0, 1,
             32'h0000_0400, 4'b1100, 32'hBEEF_BEEF);
      push(32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      mem_op("lw", 1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'hDEAD_BEEF, 3,
             32'h0000_0500, 4'b1111, 32'h0);
      // Ready on the last cycle before timeout wins over the bus error.
      push(32'h0000_0077, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      mem_op("lw_late", 1'b1, 2'b10, 1'b0, 32'h0000_0580, 32'h0, 32'h0000_0077, 15,
             32'h0000_0580, 4'b1111, 32'h0);

      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd3, 1'b1);
      push(32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      idle_inputs();
      chk("mis_lw_req", {31'd0, dmem_req}, 32'd0);
      check_retire("mis_lw");
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 5'd4, 1'b1);
      push(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      idle_inputs();
      chk("mis_sh_req", {31'd0, dmem_req}, 32'd0);
      check_retire("mis_sh");

      // Ready pulses while idle must not retire anything.
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
      chk("ready_idle_wb", {31'd0, wb_valid}, 32'd0);

      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 5'd12, 1'b1);
      push(32'h0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      idle_inputs();
      stall_cnt = 0;
      for (int i = 0; i < 40 && !wb_valid; i++) begin
         if (stall) stall_cnt++;
         step();
      end
      chk("to_req_cycles", stall_cnt, 32'd16);
      chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
      check_retire("timeout");
      drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0, 5'd2, 1'b1);
      push(32'h0000_0042, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      idle_inputs();
      check_retire("after_to");

      // Asynchronous reset in the middle of an access.
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0, 5'd8, 1'b1);
      step();
      idle_inputs();
      chk("mid_req_before", {31'd0, dmem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      chk("mid_rst_addr", dmem_addr, 32'd0);
      chk("mid_rst_wb_data", wb_data, 32'd0);
      step();
      reset = 1'b1;
      dmem_ready = 1'b1;
      dmem_rdata = 32'h1111_1111;
      step();
      dmem_ready = 1'b0;
      step();
      chk("post_rst_stall", {31'd0, stall}, 32'd0);
      chk("post_rst_wb", {31'd0, wb_valid}, 32'd0);
      chk("sb_drained", sbq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
